// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, execute-stage FSM states and the
// iterative-engine step bound.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SLL  = 6'h06;
    localparam logic [5:0] OP_SRL  = 6'h07;
    localparam logic [5:0] OP_MUL  = 6'h08;
    localparam logic [5:0] OP_DIVU = 6'h09;
    localparam logic [5:0] OP_J    = 6'h10;

    // Index of the final iteration of MUL/DIVU.
    localparam int ITER_LAST = 31;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

    function automatic logic is_multi_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative multiply / unsigned divide engine, one step per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : latch operands and begin a new operation (counter cleared)
//   is_div   : 1 = restoring division a/b, 0 = shift-add multiply a*b
//   a, b     : operands
//   last     : high while the final step (count == ITER-1) is executing
//   result   : value after the current step; valid to capture when last=1
module mul_div_iter
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_LAST + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(ITER);

    logic             run;
    logic             div_q;
    logic [CW-1:0]    cnt;

    // multiply state
    logic [WIDTH-1:0] acc, mcand, mplier;
    // divide state
    logic [WIDTH-1:0] rem, quo, dvsr;

    logic [WIDTH-1:0] acc_nxt, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    assign last = run && (cnt == CW'(ITER - 1));

    always_comb begin
        acc_nxt = mplier[0] ? acc + mcand : acc;

        // Shift the next dividend bit into the partial remainder and try a
        // subtract; one extra guard bit detects the borrow. A zero divisor
        // never borrows, so the quotient naturally saturates to all ones.
        rem_sh  = {rem, quo[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, dvsr};
        quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
        rem_nxt = diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];

        result  = div_q ? quo_nxt : acc_nxt;
    end

    // Only a non-borrowing difference is kept, and that always fits WIDTH bits.
    assign unused_diff_bit = diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 1'b0;
            div_q  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else if (start) begin
            run    <= 1'b1;
            div_q  <= is_div;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            rem    <= '0;
            quo    <= a;
            dvsr   <= b;
        end else if (run) begin
            cnt    <= cnt + 1'b1;
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            if (last)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative MUL/DIVU engine.
//   clk, rst        : clock, synchronous active-high reset
//   opcode_in       : opcode from ID/EX
//   ALU_input_1_in  : operand A
//   ALU_input_2_in  : operand B / immediate
//   load_imm_in     : pass operand B through as the result (single-cycle ops)
//   J_type_imm_in   : jump immediate, zero-extended for J
//   result_out      : registered result, held between valid pulses
//   opcode_out      : opcode that produced result_out
//   valid_out       : one-cycle pulse per new result
//   stall           : combinational hold request to upstream
module ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_LAST + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_in,
    input  logic [WIDTH-1:0] ALU_input_1_in,
    input  logic [WIDTH-1:0] ALU_input_2_in,
    input  logic             load_imm_in,
    input  logic [25:0]      J_type_imm_in,
    output logic [WIDTH-1:0] result_out,
    output logic [5:0]       opcode_out,
    output logic             valid_out,
    output logic             stall
);

    localparam int SHW = $clog2(WIDTH);

    ex_state_t        state, state_nxt;
    logic             multi, start, alu_ok, eng_last;
    logic [WIDTH-1:0] alu_res, eng_res;
    logic [5:0]       op_q;

    assign multi = is_multi_op(opcode_in);

    // Single-cycle ALU. alu_ok marks opcodes that produce a result this way;
    // NOP, unlisted and multi-cycle opcodes leave it low, which also keeps
    // load_imm_in from touching them.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (opcode_in)
            OP_ADD:  alu_res = ALU_input_1_in + ALU_input_2_in;
            OP_SUB:  alu_res = ALU_input_1_in - ALU_input_2_in;
            OP_AND:  alu_res = ALU_input_1_in & ALU_input_2_in;
            OP_OR:   alu_res = ALU_input_1_in | ALU_input_2_in;
            OP_XOR:  alu_res = ALU_input_1_in ^ ALU_input_2_in;
            OP_SLL:  alu_res = ALU_input_1_in << ALU_input_2_in[SHW-1:0];
            OP_SRL:  alu_res = ALU_input_1_in >> ALU_input_2_in[SHW-1:0];
            OP_J:    alu_res = WIDTH'(J_type_imm_in);
            default: alu_ok  = 1'b0;
        endcase
        if (load_imm_in && alu_ok)
            alu_res = ALU_input_2_in;
    end

    // In the last BUSY cycle upstream is released, but the opcode it still
    // shows is the op in flight, so nothing is accepted until IDLE.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (multi) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = !eng_last;
                if (eng_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_out <= '0;
            opcode_out <= OP_NOP;
            valid_out  <= 1'b0;
            op_q       <= OP_NOP;
        end else begin
            valid_out <= 1'b0;
            if (start) begin
                op_q <= opcode_in;
            end else if (state == BUSY && eng_last) begin
                result_out <= eng_res;
                opcode_out <= op_q;
                valid_out  <= 1'b1;
            end else if (state == IDLE && alu_ok) begin
                result_out <= alu_res;
                opcode_out <= opcode_in;
                valid_out  <= 1'b1;
            end
        end
    end

    mul_div_iter #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_mul_div (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (opcode_in == OP_DIVU),
        .a      (ALU_input_1_in),
        .b      (ALU_input_2_in),
        .last   (eng_last),
        .result (eng_res)
    );

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: per-cycle expectations built from the opcode rules,
// compared every cycle, plus hand-computed pinned results.
module tb_ex_stage;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [31:0] a_in, b_in;
    logic        li;
    logic [25:0] jimm;
    logic [31:0] result_out;
    logic [5:0]  opcode_out;
    logic        valid_out, stall;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .opcode_in      (opcode),
        .ALU_input_1_in (a_in),
        .ALU_input_2_in (b_in),
        .load_imm_in    (li),
        .J_type_imm_in  (jimm),
        .result_out     (result_out),
        .opcode_out     (opcode_out),
        .valid_out      (valid_out),
        .stall          (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit        exp_valid [N];
    bit        exp_stall [N];
    bit        exp_rst   [N];
    bit [31:0] exp_res   [N];
    bit [5:0]  exp_op    [N];
    bit        pin_en    [N];
    bit [31:0] pin_val   [N];
    bit        scnt_start[N];
    bit        scnt_chk  [N];

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour of one op presented in cycle c.
    task automatic model_op(input int c, input bit [5:0] op, input bit [31:0] a,
                            input bit [31:0] b, input bit l, input bit [25:0] j);
        bit [31:0] r;
        bit        ok;
        r  = 32'h0;
        ok = 1'b1;
        if (op == 6'h08 || op == 6'h09) begin
            for (int k = c; k < c + 32; k++) exp_stall[k] = 1'b1;
            if (op == 6'h08) r = a * b;
            else             r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            exp_valid[c+33] = 1'b1;
            exp_res[c+33]   = r;
            exp_op[c+33]    = op;
        end else begin
            case (op)
                6'h01:   r = a + b;
                6'h02:   r = a - b;
                6'h03:   r = a & b;
                6'h04:   r = a | b;
                6'h05:   r = a ^ b;
                6'h06:   r = a << b[4:0];
                6'h07:   r = a >> b[4:0];
                6'h10:   r = {6'b0, j};
                default: ok = 1'b0;
            endcase
            if (ok) begin
                if (l) r = b;
                exp_valid[c+1] = 1'b1;
                exp_res[c+1]   = r;
                exp_op[c+1]    = op;
            end
        end
    endtask

    // Present an op; upstream holds it for the whole stall window.
    task automatic drive(input bit [5:0] op, input bit [31:0] a, input bit [31:0] b,
                         input bit l, input bit [25:0] j);
        opcode = op; a_in = a; b_in = b; li = l; jimm = j;
        model_op(cyc, op, a, b, l, j);
        repeat ((op == 6'h08 || op == 6'h09) ? 33 : 1) @(posedge clk);
        #1;
    endtask

    task automatic pin(input int c, input bit [31:0] v);
        pin_en[c]  = 1'b1;
        pin_val[c] = v;
    endtask

    // Compare process: checks outputs against the expectations every cycle.
    initial begin
        bit [31:0] m_res;
        bit [5:0]  m_op;
        int        run;
        m_res = 32'h0;
        m_op  = 6'h0;
        run   = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (exp_rst[cyc]) begin
                    m_res = 32'h0;
                    m_op  = 6'h0;
                end
                if (exp_valid[cyc]) begin
                    m_res = exp_res[cyc];
                    m_op  = exp_op[cyc];
                end
                chk("valid_out",  32'(valid_out),  32'(exp_valid[cyc]));
                chk("stall",      32'(stall),      32'(exp_stall[cyc]));
                chk("result_out", result_out,      m_res);
                chk("opcode_out", 32'(opcode_out), 32'(m_op));
                if (pin_en[cyc]) chk("pinned result", result_out, pin_val[cyc]);
                if (scnt_start[cyc]) run = 0;
                if (scnt_chk[cyc]) chk("stall length", 32'(run), 32'd32);
                if (stall) run++;
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1; opcode = 6'h0; a_in = 32'h0; b_in = 32'h0; li = 1'b0; jimm = 26'h0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        exp_rst[1] = 1'b1;
        pin(1, 32'h0);
        @(posedge clk); #1;
        exp_rst[2] = 1'b1;
        rst = 1'b0;

        // ADD wraps
        pin(cyc + 1, 32'h0000_0001);
        drive(6'h01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 26'h0);
        // load-immediate then J, back to back
        pin(cyc + 1, 32'h0000_ABCD);
        drive(6'h01, 32'h1234_5678, 32'h0000_ABCD, 1'b1, 26'h0);
        pin(cyc + 1, 32'h03FF_FFFF);
        drive(6'h10, 32'h0, 32'h0, 1'b0, 26'h3FF_FFFF);

        // remaining single-cycle ops
        pin(cyc + 1, 32'hFFFF_FFFE);
        drive(6'h02, 32'h5, 32'h7, 1'b0, 26'h0);
        pin(cyc + 1, 32'hF000_F000);
        drive(6'h03, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 26'h0);
        drive(6'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 26'h0);
        pin(cyc + 1, 32'h0FF0_0FF0);
        drive(6'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 26'h0);
        pin(cyc + 1, 32'h0000_0006);
        drive(6'h06, 32'h3, 32'h21, 1'b0, 26'h0);
        pin(cyc + 1, 32'h0000_0001);
        drive(6'h07, 32'h8000_0000, 32'h1F, 1'b0, 26'h0);
        drive(6'h0A, 32'h1, 32'h1, 1'b0, 26'h0);
        drive(6'h00, 32'h1, 32'h1, 1'b0, 26'h0);

        // MUL with a counted stall window
        c0 = cyc;
        scnt_start[c0] = 1'b1;
        scnt_chk[c0+33] = 1'b1;
        pin(c0 + 33, 32'h000B_000F);
        drive(6'h08, 32'h0001_0003, 32'h0002_0005, 1'b0, 26'h0);
        drive(6'h00, 32'h0, 32'h0, 1'b0, 26'h0);

        // DIVU back to back, second one divides by zero
        pin(cyc + 33, 32'h0000_000E);
        drive(6'h09, 32'd100, 32'd7, 1'b0, 26'h0);
        pin(cyc + 33, 32'hFFFF_FFFF);
        drive(6'h09, 32'd5, 32'd0, 1'b0, 26'h0);
        // load_imm does not affect a multi-cycle op
        pin(cyc + 33, 32'h0000_002A);
        drive(6'h08, 32'd7, 32'd6, 1'b1, 26'h0);
        drive(6'h00, 32'h0, 32'h0, 1'b0, 26'h0);

        // MUL aborted by reset at count 10
        c0 = cyc;
        opcode = 6'h08; a_in = 32'd9; b_in = 32'd9; li = 1'b0;
        model_op(c0, 6'h08, 32'd9, 32'd9, 1'b0, 26'h0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1; opcode = 6'h00; a_in = 32'h0; b_in = 32'h0;
        for (int k = c0 + 12; k < c0 + 40; k++) begin
            exp_valid[k] = 1'b0;
            exp_stall[k] = 1'b0;
        end
        exp_rst[c0+12] = 1'b1;
        pin(c0 + 12, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) drive(6'h00, 32'h0, 32'h0, 1'b0, 26'h0);

        // DIVU followed directly by SLL
        c0 = cyc;
        pin(c0 + 33, 32'h0000_000E);
        pin(c0 + 34, 32'h8000_0000);
        drive(6'h09, 32'd100, 32'd7, 1'b0, 26'h0);
        drive(6'h06, 32'h1, 32'd31, 1'b0, 26'h0);
        repeat (4) drive(6'h00, 32'h0, 32'h0, 1'b0, 26'h0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the CPU pipeline, directly downstream of the ID/EX pipeline register. It consumes the registered opcode, the two ALU operands, the load-immediate flag and the J-type immediate. It produces a registered result for the EX/MEM boundary. Single-cycle ALU ops complete in one clock. MUL and DIVU run on an iterative 32-step engine and hold the front of the pipeline with `stall`.

## Interface

Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `ITER`, default 32: iterations per MUL/DIVU. Must equal `WIDTH`.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `opcode_in`, input, 6: opcode from ID/EX.
- `ALU_input_1_in`, input, 32: operand A.
- `ALU_input_2_in`, input, 32: operand B, or the immediate.
- `load_imm_in`, input, 1: when 1, the result is operand B, passed through unchanged.
- `J_type_imm_in`, input, 26: jump immediate.
- `result_out`, output, 32: registered result.
- `opcode_out`, output, 6: opcode of the op that produced `result_out`.
- `valid_out`, output, 1: one-cycle pulse marking a new `result_out`.
- `stall`, output, 1: combinational. Upstream must hold its outputs while `stall` is 1.

## Operation

Opcodes are listed as value, mnemonic, result:
- 0x00 NOP: no result; `valid_out` is 0.
- 0x01 ADD: A+B.
- 0x02 SUB: A−B.
- 0x03 AND: A&B.
- 0x04 OR: A|B.
- 0x05 XOR: A^B.
- 0x06 SLL: A << B[4:0].
- 0x07 SRL: A >> B[4:0], logical.
- 0x08 MUL: low 32 bits of A·B, unsigned, shift-add.
- 0x09 DIVU: A/B, unsigned, restoring division.
- 0x10 J: {6'b0, J_type_imm_in}.

Arithmetic rules:
- All arithmetic wraps modulo 2^32. There are no flags.
- `load_imm_in`=1 overrides the opcode select, but only for opcodes that are not multi-cycle.
- Unlisted opcodes behave as NOP.

State machine, states IDLE and BUSY:
- IDLE, op is not MUL/DIVU: result is computed combinationally and registered on the next edge. `valid_out`=1 for that one cycle, `opcode_out`=`opcode_in`.
- IDLE, op is MUL/DIVU: latch A, B and the opcode. Clear the iteration counter to 0. Go to BUSY. `stall`=1 during this cycle.
- BUSY: one iteration per cycle; the counter runs 0..31.
  - `stall`=1 while count<31.
  - `stall`=0 in the count==31 cycle, so upstream advances on that edge.
  - On that edge, the final iteration completes, `result_out` is loaded, `valid_out` is set to 1 and the state returns to IDLE.
- The `opcode_in` presented in the count==31 cycle belongs to the op already being executed. It is not re-accepted.
- DIVU with B=0: quotient is 0xFFFFFFFF. No exception.
- `valid_out` is 0 on every cycle not listed above. `result_out` and `opcode_out` hold their values when `valid_out`=0.

## Timing

- Reset values: `result_out`=0, `opcode_out`=0, `valid_out`=0, `stall`=0, state=IDLE, counter=0, engine registers=0.
- Reset during BUSY: aborts the operation on that edge. The partial result is discarded and no `valid_out` is produced.
- Single-cycle op: latency 1. `valid_out` is high the cycle after the op is presented. Back-to-back single-cycle ops give a result every cycle.
- MUL/DIVU: presented in cycle 0.
  - `stall` is high in cycles 0..31.
  - Cycle 32 is the count==31 cycle: `stall` is low.
  - `valid_out` is high in cycle 33.
  - The next op may be presented in cycle 33.
- A multi-cycle op immediately followed by another multi-cycle op: the second is accepted in cycle 33 from IDLE. There is no bubble beyond the 33-cycle occupancy.
- `stall` depends only on state, counter and `opcode_in`. It has no dependency on the operand values.

## Structure

- Shared package `cpu_pkg` holds:
  - opcode localparams `OP_NOP`..`OP_J`;
  - the `ex_state_t` enum {IDLE, BUSY};
  - `ITER_LAST` = 31.
- Sub-module `mul_div_iter` holds the shift-add / restoring-division datapath and the counter.
  - Inputs: start, is_div, A, B.
  - Outputs: last (count==31), result.
- The top level holds the single-cycle ALU, the FSM, the output registers and `stall`.

## Test plan

- ADD 0xFFFFFFFF + 0x00000002 → next cycle `result_out`=0x00000001, `valid_out`=1, `opcode_out`=0x01.
- ADD with `load_imm_in`=1, B=0x0000ABCD, then J with imm 0x3FFFFFF on the next cycle → `result_out`=0x0000ABCD, then 0x03FFFFFF, on consecutive cycles.
- MUL 0x00010003 × 0x00020005 → `stall` high for exactly 32 cycles; in cycle 33 `result_out`=0x000B000F (low 32 bits), with a single `valid_out` pulse.
- DIVU 100/7 → 0x0000000E. DIVU 5/0 → 0xFFFFFFFF. Each has the same 33-cycle latency.
- MUL presented, `rst` asserted at BUSY count 10 → next cycle all outputs are 0, `stall`=0; no `valid_out` ever appears for the aborted MUL.
- DIVU immediately followed by SLL 0x1 << 31 → SLL `valid_out` appears in cycle 34 with 0x80000000; the DIVU is not executed twice.
